datapath_mc: RTL and testbench

DATAPATH_MC -- requirements
Module: datapath_mc

---
 rtl/datapath_mc.sv | 199 +++++++++++++++++++
 tb/tb_datapath_mc.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_mc.sv
// Multicycle 8-register datapath: FETCH -> DECODE -> EXEC -> [MEM] -> WB, with a single
// shared memory port that stalls on waitrequest.
module datapath_mc #(
    parameter int          DATA_W   = 16,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [DATA_W-1:0] o_mem_addr,
    output logic              o_mem_rd,
    input  logic [DATA_W-1:0] i_mem_rddata,
    output logic              o_mem_wr,
    output logic [DATA_W-1:0] o_mem_wrdata,
    input  logic              i_mem_waitrequest,
    output logic [DATA_W-1:0] o_pc,
    output logic              o_N,
    output logic              o_Z,
    output logic              o_instr_done
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
    } state_t;

    localparam logic [4:0] OP_MV    = 5'b00000;
    localparam logic [4:0] OP_ADD   = 5'b00001;
    localparam logic [4:0] OP_SUB   = 5'b00010;
    localparam logic [4:0] OP_CMP   = 5'b00011;
    localparam logic [4:0] OP_LD    = 5'b00100;
    localparam logic [4:0] OP_ST    = 5'b00101;
    localparam logic [4:0] OP_JR    = 5'b01000;
    localparam logic [4:0] OP_JZR   = 5'b01001;
    localparam logic [4:0] OP_JNR   = 5'b01010;
    localparam logic [4:0] OP_CALLR = 5'b01100;
    localparam logic [4:0] OP_MVI   = 5'b10000;
    localparam logic [4:0] OP_ADDI  = 5'b10001;
    localparam logic [4:0] OP_SUBI  = 5'b10010;
    localparam logic [4:0] OP_CMPI  = 5'b10011;
    localparam logic [4:0] OP_MVHI  = 5'b10110;
    localparam logic [4:0] OP_J     = 5'b11000;
    localparam logic [4:0] OP_JZ    = 5'b11001;
    localparam logic [4:0] OP_JN    = 5'b11010;
    localparam logic [4:0] OP_CALL  = 5'b11100;

    localparam logic [DATA_W-1:0] PC_RST = DATA_W'(RESET_PC);

    function automatic logic signed [DATA_W-1:0] sext8(input logic [7:0] v);
        return {{(DATA_W-8){v[7]}}, v};
    endfunction

    function automatic logic signed [DATA_W-1:0] sext11(input logic [10:0] v);
        return {{(DATA_W-11){v[10]}}, v};
    endfunction

    state_t             state_q, state_d;
    logic [15:0]        ir_q;
    logic [DATA_W-1:0]  pc_q;
    logic [DATA_W-1:0]  rf_q [8];
    logic               n_q, z_q;
    logic               wb_en_q;
    logic [2:0]         wb_idx_q;
    logic [DATA_W-1:0]  a_q, b_q, res_q;

    logic [4:0]                opcode;
    logic [2:0]                rx, ry;
    logic signed [DATA_W-1:0]  imm8_sx, imm11_sx;
    logic                      is_ld;

    assign opcode   = ir_q[4:0];
    assign rx       = ir_q[7:5];
    assign ry       = ir_q[10:8];
    assign imm8_sx  = sext8(ir_q[15:8]);
    assign imm11_sx = sext11(ir_q[15:5]);
    assign is_ld    = (opcode == OP_LD);

    logic [DATA_W-1:0] exe_res, exe_target;
    logic [2:0]        exe_idx;
    logic              exe_wb, exe_flags, exe_jump, exe_mem;

    // EXEC-stage decode: result, flag update, writeback and branch resolution
    always_comb begin
        exe_res    = b_q;
        exe_idx    = rx;
        exe_wb     = 1'b0;
        exe_flags  = 1'b0;
        exe_jump   = 1'b0;
        exe_mem    = 1'b0;
        exe_target = a_q;
        case (opcode)
            OP_MV:   begin exe_res = b_q;           exe_wb = 1'b1; end
            OP_ADD:  begin exe_res = a_q + b_q;     exe_wb = 1'b1; exe_flags = 1'b1; end
            OP_SUB:  begin exe_res = a_q - b_q;     exe_wb = 1'b1; exe_flags = 1'b1; end
            OP_CMP:  begin exe_res = a_q - b_q;     exe_flags = 1'b1; end
            OP_LD:   begin exe_mem = 1'b1;          exe_wb = 1'b1; end
            OP_ST:   exe_mem = 1'b1;
            OP_MVI:  begin exe_res = imm8_sx;       exe_wb = 1'b1; end
            OP_ADDI: begin exe_res = a_q + imm8_sx; exe_wb = 1'b1; exe_flags = 1'b1; end
            OP_SUBI: begin exe_res = a_q - imm8_sx; exe_wb = 1'b1; exe_flags = 1'b1; end
            OP_CMPI: begin exe_res = a_q - imm8_sx; exe_flags = 1'b1; end
            OP_MVHI: begin
                exe_res        = a_q;
                exe_res[15:8]  = ir_q[15:8];
                exe_wb         = 1'b1;
            end
            OP_JR:    exe_jump = 1'b1;
            OP_JZR:   exe_jump = z_q;
            OP_JNR:   exe_jump = n_q;
            OP_CALLR: begin
                exe_jump = 1'b1;
                exe_res  = pc_q;
                exe_idx  = 3'd7;
                exe_wb   = 1'b1;
            end
            OP_J:  begin exe_jump = 1'b1; exe_target = pc_q + (imm11_sx <<< 1); end
            OP_JZ: begin exe_jump = z_q;  exe_target = pc_q + (imm11_sx <<< 1); end
            OP_JN: begin exe_jump = n_q;  exe_target = pc_q + (imm11_sx <<< 1); end
            OP_CALL: begin
                exe_jump   = 1'b1;
                exe_target = pc_q + (imm11_sx <<< 1);
                exe_res    = pc_q;
                exe_idx    = 3'd7;
                exe_wb     = 1'b1;
            end
            default: ;
        endcase
    end

    // Memory outputs are masked by reset so an access cannot be issued while reset is held
    always_comb begin
        state_d      = state_q;
        o_mem_rd     = 1'b0;
        o_mem_wr     = 1'b0;
        o_mem_addr   = pc_q;
        o_instr_done = 1'b0;
        case (state_q)
            S_FETCH: begin
                o_mem_rd = ~reset;
                if (!i_mem_waitrequest) state_d = S_DECODE;
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = exe_mem ? S_MEM : S_WB;
            S_MEM: begin
                o_mem_addr = b_q;
                o_mem_rd   = is_ld & ~reset;
                o_mem_wr   = ~is_ld & ~reset;
                if (!i_mem_waitrequest) state_d = S_WB;
            end
            S_WB: begin
                o_instr_done = ~reset;
                state_d      = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= PC_RST;
            ir_q    <= '0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            wb_en_q <= 1'b0;
            for (int i = 0; i < 8; i++) rf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_FETCH && !i_mem_waitrequest) ir_q <= i_mem_rddata[15:0];
            if (state_q == S_DECODE) pc_q <= pc_q + DATA_W'(2);
            if (state_q == S_EXEC) begin
                if (exe_jump) pc_q <= exe_target;
                if (exe_flags) begin
                    n_q <= exe_res[DATA_W-1];
                    z_q <= (exe_res == '0);
                end
                wb_en_q <= exe_wb;
            end
            if (state_q == S_WB && wb_en_q) rf_q[wb_idx_q] <= res_q;
        end
    end

    // Operand and result registers carry data only and need no reset
    always_ff @(posedge clk) begin
        if (state_q == S_DECODE) begin
            a_q <= rf_q[rx];
            b_q <= rf_q[ry];
        end
        if (state_q == S_EXEC) begin
            res_q    <= exe_res;
            wb_idx_q <= exe_idx;
        end
        if (state_q == S_MEM && is_ld && !i_mem_waitrequest) res_q <= i_mem_rddata;
    end

    assign o_pc         = pc_q;
    assign o_N          = n_q;
    assign o_Z          = z_q;
    assign o_mem_wrdata = a_q;

endmodule

// File: tb/tb_datapath_mc.sv
// Directed bench for datapath_mc: a 16-bit instance (RESET_PC=0) and a 32-bit instance
// (RESET_PC=0x100) driven instruction by instruction from a behavioural memory port.
module tb_datapath_mc;

    localparam logic [4:0] OP_ADD  = 5'b00001;
    localparam logic [4:0] OP_LD   = 5'b00100;
    localparam logic [4:0] OP_ST   = 5'b00101;
    localparam logic [4:0] OP_JR   = 5'b01000;
    localparam logic [4:0] OP_JZR  = 5'b01001;
    localparam logic [4:0] OP_MVI  = 5'b10000;
    localparam logic [4:0] OP_SUBI = 5'b10010;
    localparam logic [4:0] OP_CMPI = 5'b10011;
    localparam logic [4:0] OP_MVHI = 5'b10110;
    localparam logic [4:0] OP_JZ   = 5'b11001;
    localparam logic [4:0] OP_JN   = 5'b11010;
    localparam logic [4:0] OP_CALL = 5'b11100;
    localparam logic [4:0] OP_UNDEF = 5'b00111;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] rddata;
    logic        waitreq;

    logic [15:0] addr16, wrdata16, pc16;
    logic        rd16, wr16, n16, z16, done16;
    logic [31:0] addr32, wrdata32, pc32;
    logic        rd32, wr32, n32, z32, done32;

    logic        sel32;
    logic [31:0] obs_addr, obs_wrdata, obs_pc;
    logic        obs_rd, obs_wr, obs_N, obs_Z, obs_done;

    int errors = 0;
    int checks = 0;

    int          last_cycles, last_mem_cycles, last_wr_cycles;
    logic [31:0] last_faddr, last_maddr, last_wrdata;
    logic        both_seen = 1'b0;

    always #5 clk = ~clk;

    datapath_mc #(.DATA_W(16), .RESET_PC(0)) dut16 (
        .clk(clk), .reset(reset),
        .o_mem_addr(addr16), .o_mem_rd(rd16), .i_mem_rddata(rddata[15:0]),
        .o_mem_wr(wr16), .o_mem_wrdata(wrdata16), .i_mem_waitrequest(waitreq),
        .o_pc(pc16), .o_N(n16), .o_Z(z16), .o_instr_done(done16)
    );

    datapath_mc #(.DATA_W(32), .RESET_PC(32'h100)) dut32 (
        .clk(clk), .reset(reset),
        .o_mem_addr(addr32), .o_mem_rd(rd32), .i_mem_rddata(rddata),
        .o_mem_wr(wr32), .o_mem_wrdata(wrdata32), .i_mem_waitrequest(waitreq),
        .o_pc(pc32), .o_N(n32), .o_Z(z32), .o_instr_done(done32)
    );

    always_comb begin
        obs_addr   = sel32 ? addr32   : {16'h0, addr16};
        obs_wrdata = sel32 ? wrdata32 : {16'h0, wrdata16};
        obs_pc     = sel32 ? pc32     : {16'h0, pc16};
        obs_rd     = sel32 ? rd32     : rd16;
        obs_wr     = sel32 ? wr32     : wr16;
        obs_N      = sel32 ? n32      : n16;
        obs_Z      = sel32 ? z32      : z16;
        obs_done   = sel32 ? done32   : done16;
    end

    function automatic logic [15:0] er(input logic [4:0] op, input logic [2:0] rx, input logic [2:0] ry);
        return {5'b0, ry, rx, op};
    endfunction

    function automatic logic [15:0] ei(input logic [4:0] op, input logic [2:0] rx, input logic [7:0] imm);
        return {imm, rx, op};
    endfunction

    function automatic logic [15:0] ej(input logic [4:0] op, input logic [10:0] imm);
        return {imm, op};
    endfunction

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One instruction: supply it on the fetch, serve any memory access after the fetch with
    // mem_waits stall cycles, and stop at the retire pulse.
    task automatic run(input logic [15:0] instr, input int mem_waits, input logic [31:0] ld_data);
        int   n       = 0;
        int   w       = mem_waits;
        logic fetched = 1'b0;
        logic done    = 1'b0;
        last_mem_cycles = 0;
        last_wr_cycles  = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (obs_rd && obs_wr) both_seen = 1'b1;
            waitreq = 1'b0;
            rddata  = 32'h0;
            if (!fetched && obs_rd) begin
                last_faddr = obs_addr;
                rddata     = {16'hDEAD, instr};
                fetched    = 1'b1;
            end else if (fetched && (obs_rd || obs_wr)) begin
                last_mem_cycles++;
                if (obs_wr) last_wr_cycles++;
                last_maddr  = obs_addr;
                last_wrdata = obs_wrdata;
                if (w > 0) begin
                    waitreq = 1'b1;
                    w--;
                end else begin
                    rddata = ld_data;
                end
            end
            if (obs_done) done = 1'b1;
        end
        last_cycles = n;
        chk("retired", {31'h0, done}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sel32   = 1'b0;
        reset   = 1'b1;
        waitreq = 1'b0;
        rddata  = 32'h0;

        // ---- 16-bit instance: reset behaviour
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rd", {31'h0, obs_rd}, 32'h0);
        chk("rst_wr", {31'h0, obs_wr}, 32'h0);
        chk("rst_done", {31'h0, obs_done}, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("first_fetch_rd", {31'h0, obs_rd}, 32'h1);
        chk("first_fetch_addr", obs_addr, 32'h0);
        chk("rst_flags", {30'h0, obs_N, obs_Z}, 32'h0);

        // mvi R1,5 ; mvi R2,0xFB ; add R1,R2 -> 0, Z=1
        run(ei(OP_MVI, 3'd1, 8'h05), 0, 0);
        chk("mvi_cycles", last_cycles, 4);
        run(ei(OP_MVI, 3'd2, 8'hFB), 0, 0);
        chk("mvi2_cycles", last_cycles, 4);
        run(er(OP_ADD, 3'd1, 3'd2), 0, 0);
        chk("add_cycles", last_cycles, 4);
        chk("add_flags_NZ", {30'h0, obs_N, obs_Z}, 32'h1);
        chk("pc_after_3", obs_pc, 32'h6);
        run(er(OP_ST, 3'd1, 3'd0), 0, 0);
        chk("st_r1_data", last_wrdata, 32'h0);
        chk("st_r1_addr", last_maddr, 32'h0);
        chk("st_cycles", last_cycles, 5);
        chk("st_flags_kept", {30'h0, obs_N, obs_Z}, 32'h1);

        // mvi R3,0x12 ; mvhi R3,0xAB ; mvi R4,0x40 ; st R3,[R4] with 3 waits
        run(ei(OP_MVI, 3'd3, 8'h12), 0, 0);
        run(ei(OP_MVHI, 3'd3, 8'hAB), 0, 0);
        run(ei(OP_MVI, 3'd4, 8'h40), 0, 0);
        run(er(OP_ST, 3'd3, 3'd4), 3, 0);
        chk("st_wait_wr_cycles", last_wr_cycles, 4);
        chk("st_wait_addr", last_maddr, 32'h40);
        chk("st_wait_data", last_wrdata, 32'hAB12);
        chk("st_wait_cycles", last_cycles, 8);
        chk("pc_at_call", obs_pc, 32'h10);

        // call -4 at 0x10 -> PC 0x0A, R7 0x12 ; jr R7 -> 0x12
        run(ej(OP_CALL, 11'h7FC), 0, 0);
        chk("call_cycles", last_cycles, 4);
        chk("call_pc", obs_pc, 32'h0A);
        run(er(OP_JR, 3'd7, 3'd0), 0, 0);
        chk("jr_fetch_addr", last_faddr, 32'h0A);
        chk("jr_pc", obs_pc, 32'h12);
        run(er(OP_ST, 3'd7, 3'd0), 0, 0);
        chk("link_value", last_wrdata, 32'h12);

        // R6 = 0x0100 ; cmpi R0,1 -> N=1 Z=0 ; ld R5,[R6] leaves flags alone
        run(ei(OP_MVI, 3'd6, 8'h00), 0, 0);
        run(ei(OP_MVHI, 3'd6, 8'h01), 0, 0);
        run(ei(OP_CMPI, 3'd0, 8'h01), 0, 0);
        chk("cmpi_neg_flags", {30'h0, obs_N, obs_Z}, 32'h2);
        run(er(OP_LD, 3'd5, 3'd6), 0, 32'h8001);
        chk("ld_cycles", last_cycles, 5);
        chk("ld_addr", last_maddr, 32'h100);
        chk("ld_wr_none", last_wr_cycles, 0);
        chk("ld_flags_kept", {30'h0, obs_N, obs_Z}, 32'h2);
        run(er(OP_ST, 3'd5, 3'd0), 0, 0);
        chk("ld_value", last_wrdata, 32'h8001);
        chk("pc_before_br", obs_pc, 32'h1E);

        // cmpi R0,0 ; jz +3 taken ; R0=1 ; cmpi R0,0 ; jz +3 not taken
        run(ei(OP_CMPI, 3'd0, 8'h00), 0, 0);
        chk("cmpi_zero_flags", {30'h0, obs_N, obs_Z}, 32'h1);
        run(ej(OP_JZ, 11'd3), 0, 0);
        chk("jz_taken_pc", obs_pc, 32'h28);
        run(ei(OP_MVI, 3'd0, 8'h01), 0, 0);
        run(ei(OP_CMPI, 3'd0, 8'h00), 0, 0);
        chk("cmpi_one_flags", {30'h0, obs_N, obs_Z}, 32'h0);
        run(ej(OP_JZ, 11'd3), 0, 0);
        chk("jz_not_taken_pc", obs_pc, 32'h2E);

        // cmpi R0,2 -> N=1 ; jn -8 at 0x30 -> 0x22 ; undefined opcode ; jzr not taken
        run(ei(OP_CMPI, 3'd0, 8'h02), 0, 0);
        run(ej(OP_JN, 11'h7F8), 0, 0);
        chk("jn_taken_pc", obs_pc, 32'h22);
        run(er(OP_UNDEF, 3'd1, 3'd2), 0, 0);
        chk("nop_cycles", last_cycles, 4);
        chk("nop_pc", obs_pc, 32'h24);
        chk("nop_no_mem", last_mem_cycles, 0);
        chk("nop_flags", {30'h0, obs_N, obs_Z}, 32'h2);
        run(er(OP_JZR, 3'd4, 3'd0), 0, 0);
        chk("jzr_not_taken_pc", obs_pc, 32'h26);

        // ---- 32-bit instance
        sel32 = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        waitreq = 1'b0;
        rddata  = 32'h0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("w32_first_addr", obs_addr, 32'h100);
        run(ei(OP_MVI, 3'd1, 8'h80), 0, 0);
        chk("w32_mvi_faddr", last_faddr, 32'h100);
        run(ei(OP_SUBI, 3'd1, 8'h01), 0, 0);
        chk("w32_subi_flags", {30'h0, obs_N, obs_Z}, 32'h2);
        run(er(OP_ST, 3'd1, 3'd0), 0, 0);
        chk("w32_subi_value", last_wrdata, 32'hFFFFFF7F);

        // Reset while the next fetch is stalled
        @(negedge clk);
        waitreq = 1'b1;
        chk("w32_stall_rd", {31'h0, obs_rd}, 32'h1);
        chk("w32_stall_addr", obs_addr, 32'h106);
        @(negedge clk);
        chk("w32_stall_held", {31'h0, obs_rd}, 32'h1);
        reset = 1'b1;
        @(negedge clk);
        waitreq = 1'b0;
        chk("w32_rst_rd_drop", {31'h0, obs_rd}, 32'h0);
        chk("w32_rst_pc", obs_pc, 32'h100);
        chk("w32_rst_flags", {30'h0, obs_N, obs_Z}, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("w32_refetch_rd", {31'h0, obs_rd}, 32'h1);
        chk("w32_refetch_addr", obs_addr, 32'h100);
        run(ei(OP_MVI, 3'd2, 8'h01), 0, 0);
        chk("w32_after_rst_cycles", last_cycles, 4);

        chk("rd_wr_exclusive", {31'h0, both_seen}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
